sprite_mover: RTL

Parametrised sprite-movement controller: accepts rate-limited diagonal step requests, computes the candidate position, bounds-checks it, queries an external walk-map block over a request/response handshake (with portal/teleport support and timeout), then sequences background-erase and character-draw requests to the sprite drawer. It sits between the input decoder and the sprite drawer FSM, and replaces the fixed-path movement FSM with a map-agnostic, width/speed-configurable version that also supports position loading.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_mover_tick_gen.sv | 40 ++++
 rtl/sprite_mover.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types for the sprite movement controller: FSM states and step directions.
package sprite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_ERASE  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DRAW   = 3'd4
    } state_e;

    // D = y grows, U = y shrinks; R = x grows, L = x shrinks
    typedef enum logic [1:0] {
        DIR_DR = 2'd0,
        DIR_DL = 2'd1,
        DIR_UR = 2'd2,
        DIR_UL = 2'd3
    } dir_e;

endpackage

// File: rtl/sprite_mover_tick_gen.sv
// Free-running move-rate divider; tick_o is high while the counter sits on its last value.
module tick_gen #(
    parameter int TICK_DIV = 6250000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;

    // Next count wraps to zero after the last value.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter and registered tick, aligned so tick_q is high exactly when cnt_q == LAST.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= (LAST == '0);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/sprite_mover.sv
// Sprite movement controller: rate-limited diagonal steps, bounds and walk-map check,
// then erase/update/draw sequencing towards the sprite drawer.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int X_MAX       = 319,
    parameter int Y_MAX       = 239,
    parameter int STEP        = 1,
    parameter int TICK_DIV    = 6250000,
    parameter int MAP_TIMEOUT = 15,
    parameter int START_X     = 95,
    parameter int START_Y     = 221
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           move_i,
    input  logic [1:0]     dir_i,
    input  logic           load_pos_i,
    input  logic [X_W-1:0] load_x_i,
    input  logic [Y_W-1:0] load_y_i,
    output logic           walk_req_o,
    output logic [X_W-1:0] walk_x_o,
    output logic [Y_W-1:0] walk_y_o,
    input  logic           walk_valid_i,
    input  logic           walk_ok_i,
    input  logic           walk_tp_i,
    input  logic [X_W-1:0] walk_tp_x_i,
    input  logic [Y_W-1:0] walk_tp_y_i,
    output logic           draw_bg_o,
    input  logic           done_bg_i,
    output logic           draw_char_o,
    input  logic           done_char_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           busy_o,
    output logic           moved_o,
    output logic           blocked_o,
    output logic           map_timeout_o
);

    localparam int TO_W = (MAP_TIMEOUT > 1) ? $clog2(MAP_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MAP_TIMEOUT - 1);
    localparam logic signed [X_W:0] STEP_X = (X_W + 1)'(STEP);
    localparam logic signed [Y_W:0] STEP_Y = (Y_W + 1)'(STEP);
    localparam logic signed [X_W:0] LIM_X  = (X_W + 1)'(X_MAX);
    localparam logic signed [Y_W:0] LIM_Y  = (Y_W + 1)'(Y_MAX);
    localparam logic signed [X_W:0] ZERO_X = '0;
    localparam logic signed [Y_W:0] ZERO_Y = '0;

    state_e                 state_q;
    logic [X_W-1:0]         x_q, tgt_x_q, walk_x_q;
    logic [Y_W-1:0]         y_q, tgt_y_q, walk_y_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic                   walk_req_q, draw_bg_q, draw_char_q, busy_q;
    logic                   moved_q, blocked_q, map_to_q;
    logic                   tick_s;
    logic signed [X_W:0]    cand_x_d;
    logic signed [Y_W:0]    cand_y_d;
    logic                   in_bounds_d;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (tick_s)
    );

    // Candidate position one step away, with a spare sign bit so underflow is visible.
    always_comb begin
        cand_x_d = $signed({1'b0, x_q}) + STEP_X;
        cand_y_d = $signed({1'b0, y_q}) + STEP_Y;
        case (dir_e'(dir_i))
            DIR_DR: begin
                cand_x_d = $signed({1'b0, x_q}) + STEP_X;
                cand_y_d = $signed({1'b0, y_q}) + STEP_Y;
            end
            DIR_DL: begin
                cand_x_d = $signed({1'b0, x_q}) - STEP_X;
                cand_y_d = $signed({1'b0, y_q}) + STEP_Y;
            end
            DIR_UR: begin
                cand_x_d = $signed({1'b0, x_q}) + STEP_X;
                cand_y_d = $signed({1'b0, y_q}) - STEP_Y;
            end
            DIR_UL: begin
                cand_x_d = $signed({1'b0, x_q}) - STEP_X;
                cand_y_d = $signed({1'b0, y_q}) - STEP_Y;
            end
            default: begin
                cand_x_d = $signed({1'b0, x_q}) + STEP_X;
                cand_y_d = $signed({1'b0, y_q}) + STEP_Y;
            end
        endcase
        in_bounds_d = (cand_x_d > ZERO_X) && (cand_y_d > ZERO_Y) &&
                      (cand_x_d <= LIM_X) && (cand_y_d <= LIM_Y);
    end

    // Control FSM; every output is a flop set on the transition into its state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            x_q         <= X_W'(START_X);
            y_q         <= Y_W'(START_Y);
            tgt_x_q     <= '0;
            tgt_y_q     <= '0;
            walk_x_q    <= '0;
            walk_y_q    <= '0;
            to_cnt_q    <= '0;
            walk_req_q  <= 1'b0;
            draw_bg_q   <= 1'b0;
            draw_char_q <= 1'b0;
            busy_q      <= 1'b0;
            moved_q     <= 1'b0;
            blocked_q   <= 1'b0;
            map_to_q    <= 1'b0;
        end else begin
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
            map_to_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_pos_i) begin
                        tgt_x_q   <= load_x_i;
                        tgt_y_q   <= load_y_i;
                        draw_bg_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ERASE;
                    end else if (move_i && tick_s) begin
                        if (!in_bounds_d) begin
                            blocked_q <= 1'b1;
                        end else begin
                            walk_x_q   <= cand_x_d[X_W-1:0];
                            walk_y_q   <= cand_y_d[Y_W-1:0];
                            to_cnt_q   <= '0;
                            walk_req_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (walk_valid_i) begin
                        walk_req_q <= 1'b0;
                        if (walk_ok_i) begin
                            tgt_x_q   <= walk_tp_i ? walk_tp_x_i : walk_x_q;
                            tgt_y_q   <= walk_tp_i ? walk_tp_y_i : walk_y_q;
                            draw_bg_q <= 1'b1;
                            state_q   <= ST_ERASE;
                        end else begin
                            blocked_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        walk_req_q <= 1'b0;
                        blocked_q  <= 1'b1;
                        map_to_q   <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                ST_ERASE: begin
                    if (done_bg_i) begin
                        draw_bg_q <= 1'b0;
                        state_q   <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    x_q         <= tgt_x_q;
                    y_q         <= tgt_y_q;
                    draw_char_q <= 1'b1;
                    state_q     <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (done_char_i) begin
                        draw_char_q <= 1'b0;
                        moved_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    walk_req_q  <= 1'b0;
                    draw_bg_q   <= 1'b0;
                    draw_char_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign walk_req_o    = walk_req_q;
    assign walk_x_o      = walk_x_q;
    assign walk_y_o      = walk_y_q;
    assign draw_bg_o     = draw_bg_q;
    assign draw_char_o   = draw_char_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign busy_o        = busy_q;
    assign moved_o       = moved_q;
    assign blocked_o     = blocked_q;
    assign map_timeout_o = map_to_q;

endmodule
